// File: rtl/aes_ks_pkg.sv
// aes_ks_pkg: key-length encodings, schedule lookups, GF(2^8) helpers and the AES S-box
package aes_ks_pkg;
  typedef enum logic [1:0] {KL_128 = 2'd0, KL_192 = 2'd1, KL_256 = 2'd2, KL_BAD = 2'd3} key_len_e;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EXPAND = 2'd2} state_e;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [3:0] nk_of(input key_len_e kl);
    return kl == KL_128 ? 4'd4 : kl == KL_192 ? 4'd6 : 4'd8;
  endfunction
  function automatic logic [3:0] nr_of(input key_len_e kl);
    return kl == KL_128 ? 4'd10 : kl == KL_192 ? 4'd12 : 4'd14;
  endfunction
  function automatic logic [5:0] total_of(input key_len_e kl);
    return kl == KL_128 ? 6'd44 : kl == KL_192 ? 6'd52 : 6'd60;
  endfunction
  // entry 0 sits in the MSBs, so byte x lives at bit offset 8*(255-x)
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      a[k] = c[31-8*k -: 8];
      x2 = xtime(a[k]);
      x4 = xtime(x2);
      x8 = xtime(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    for (int k = 0; k < 4; k++)
      r[31-8*k -: 8] = me[k] ^ mb[(k+1)%4] ^ md[(k+2)%4] ^ m9[(k+3)%4];
    return r;
  endfunction
endpackage

// File: rtl/aes_key_sched_iter_if.sv
// aes_key_sched_iter_if: start/key bundle plus round-key read port; rd_inv exists only with AES_KS_INV_KEY_EN
interface aes_key_sched_iter_if #(parameter int KEY_W_MAX = 256);
  logic start;
  logic [1:0] key_len;
  logic [KEY_W_MAX-1:0] key_in;
  logic busy;
  logic done;
  logic keys_valid;
  logic [3:0] nr;
  logic rd_en;
  logic [3:0] rd_round;
  logic [127:0] rd_key;
  logic rd_valid;
  logic err;
`ifdef AES_KS_INV_KEY_EN
  logic rd_inv;
`endif
  modport master (
`ifdef AES_KS_INV_KEY_EN
    output rd_inv,
`endif
    output start, key_len, key_in, rd_en, rd_round,
    input busy, done, keys_valid, nr, rd_key, rd_valid, err
  );
  modport slave (
`ifdef AES_KS_INV_KEY_EN
    input rd_inv,
`endif
    input start, key_len, key_in, rd_en, rd_round,
    output busy, done, keys_valid, nr, rd_key, rd_valid, err
  );
endinterface

// File: rtl/aes_sub_word.sv
// aes_sub_word: combinational SubWord, four parallel S-box lookups
module aes_sub_word
  import aes_ks_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] y
);
  assign y = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
endmodule

// File: rtl/aes_key_sched_iter.sv
// aes_key_sched_iter: one-word-per-cycle AES-128/192/256 key expansion with a registered round-key read port
// AES_KS_INV_KEY_EN: adds rd_inv, returning InvMixColumns'd middle round keys for the equivalent inverse cipher
module aes_key_sched_iter
  import aes_ks_pkg::*;
#(
  parameter int KEY_W_MAX = 256,
  parameter int RK_WORDS  = 60
) (
  input logic clk,
  input logic rst_n,
  aes_key_sched_iter_if.slave bus
);
  localparam int AW = $clog2(RK_WORDS);
  state_e state, state_d;
  key_len_e kl;
  logic [31:0] rf [RK_WORDS];
  logic [AW-1:0] i, rd_base;
  logic [2:0] j;
  logic [7:0] rcon;
  logic [3:0] nk;
  logic [31:0] prev, back, sw_in, sw, t;
  logic start_ok, last, rd_bad;
  logic [127:0] rk, rk_out;
  assign nk = nk_of(kl);
  assign prev = rf[i - AW'(1)];
  assign back = rf[i - AW'(nk)];
  assign start_ok = state == IDLE && bus.start && bus.key_len != KL_BAD;
  assign last = i == AW'(total_of(kl) - 6'd1);
  assign sw_in = j == 3'd0 ? rot_word(prev) : prev;
  aes_sub_word u_sub (.a(sw_in), .y(sw));
  // j tracks i mod Nk so no divider is needed
  assign t = j == 3'd0 ? sw ^ {rcon, 24'h0} : (nk == 4'd8 && j == 3'd4) ? sw : prev;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start_ok ? LOAD : IDLE;
      LOAD:    state_d = EXPAND;
      EXPAND:  state_d = last ? IDLE : EXPAND;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      kl <= KL_128;
      i <= '0;
      j <= '0;
      rcon <= '0;
      bus.nr <= '0;
      bus.keys_valid <= 1'b0;
      bus.done <= 1'b0;
      for (int k = 0; k < RK_WORDS; k++) rf[k] <= '0;
    end else begin
      state <= state_d;
      bus.done <= state == EXPAND && last;
      if (start_ok) begin
        kl <= key_len_e'(bus.key_len);
        bus.nr <= nr_of(key_len_e'(bus.key_len));
        bus.keys_valid <= 1'b0;
      end
      if (state == LOAD) begin
        for (int k = 0; k < 8; k++)
          if (k < int'(nk)) rf[k] <= bus.key_in[KEY_W_MAX-1-32*k -: 32];
        i <= AW'(nk);
        j <= 3'd0;
        rcon <= 8'h01;
      end
      if (state == EXPAND) begin
        rf[i] <= back ^ t;
        i <= i + AW'(1);
        j <= {1'b0, j} == nk - 4'd1 ? 3'd0 : j + 3'd1;
        if (j == 3'd0) rcon <= xtime(rcon);
        if (last) bus.keys_valid <= 1'b1;
      end
    end
  assign rd_bad = !bus.keys_valid || bus.rd_round > bus.nr;
  assign rd_base = AW'({bus.rd_round, 2'b00});
  assign rk = {rf[rd_base], rf[rd_base + AW'(1)], rf[rd_base + AW'(2)], rf[rd_base + AW'(3)]};
`ifdef AES_KS_INV_KEY_EN
  logic inv;
  assign inv = bus.rd_inv && bus.rd_round != 4'd0 && bus.rd_round != bus.nr;
  assign rk_out = inv ? {inv_mix_col(rk[127:96]), inv_mix_col(rk[95:64]),
                         inv_mix_col(rk[63:32]), inv_mix_col(rk[31:0])} : rk;
`else
  assign rk_out = rk;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.rd_valid <= 1'b0;
      bus.rd_key <= '0;
      bus.err <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      bus.err <= (state == IDLE && bus.start && bus.key_len == KL_BAD) || (bus.rd_en && rd_bad);
      if (bus.rd_en) bus.rd_key <= rd_bad ? '0 : rk_out;
    end
endmodule

// File: tb/tb_aes_key_sched_iter.sv
// tb_aes_key_sched_iter: directed FIPS-197 vectors against the iterative AES key schedule
`timescale 1ns/1ps
module tb_aes_key_sched_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;
  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] JUNK = 128'hdeadbeefcafef00d0123456789abcdef;
  aes_key_sched_iter_if bus();
  aes_key_sched_iter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expand(input logic [1:0] len, input logic [255:0] key, input int poke,
                        output int lat, output logic saw_err);
    bus.key_len = len;
    bus.key_in = key;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 0;
    saw_err = 1'b0;
    while (!bus.done && lat < 100) begin
      bus.start = lat == poke;
      bus.key_len = lat == poke ? 2'd3 : len;
      step();
      bus.start = 1'b0;
      bus.key_len = len;
      saw_err |= bus.err;
      lat++;
    end
  endtask
  task automatic rd(input logic [3:0] r);
    bus.rd_en = 1'b1;
    bus.rd_round = r;
`ifdef AES_KS_INV_KEY_EN
    bus.rd_inv = 1'b0;
`endif
    step();
    bus.rd_en = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.busy, bus.done, bus.keys_valid, bus.nr, bus.rd_valid, bus.err, bus.rd_key} !== '0) begin
      $display("FAIL reset_outputs: got busy=%b done=%b kv=%b nr=%0d rv=%b err=%b key=%h expected all zero",
               bus.busy, bus.done, bus.keys_valid, bus.nr, bus.rd_valid, bus.err, bus.rd_key);
      fails++;
    end
    rst_n = 1'b1;
    step();
    rd(4'd0);
    checks++;
    if ({bus.rd_valid, bus.err, bus.rd_key} !== {2'b11, 128'h0}) begin
      $display("FAIL read_before_expand: got rv=%b err=%b key=%h expected rv=1 err=1 key=0",
               bus.rd_valid, bus.err, bus.rd_key);
      fails++;
    end
  endtask
  task automatic test_aes128();
    int lat;
    logic e;
    expand(2'd0, {K128, JUNK}, -1, lat, e);
    checks++;
    if (lat !== 41) begin $display("FAIL lat128: got %0d expected 41", lat); fails++; end
    checks++;
    if ({bus.busy, bus.keys_valid, bus.nr, e} !== {1'b0, 1'b1, 4'd10, 1'b0}) begin
      $display("FAIL done128_state: got busy=%b kv=%b nr=%0d err=%b expected busy=0 kv=1 nr=10 err=0",
               bus.busy, bus.keys_valid, bus.nr, e);
      fails++;
    end
    step();
    checks++;
    if (bus.done !== 1'b0) begin $display("FAIL done_pulse_width: got %b expected 0", bus.done); fails++; end
    rd(4'd10);
    checks++;
    if ({bus.rd_valid, bus.err, bus.rd_key} !== {2'b10, R128_10}) begin
      $display("FAIL r128_10: got rv=%b err=%b key=%h expected rv=1 err=0 key=%h", bus.rd_valid, bus.err, bus.rd_key, R128_10);
      fails++;
    end
    rd(4'd0);
    checks++;
    if (bus.rd_key !== K128) begin $display("FAIL r128_0: got %h expected %h", bus.rd_key, K128); fails++; end
  endtask
  task automatic test_back_to_back();
    bus.rd_en = 1'b1;
    bus.rd_round = 4'd1;
    step();
    checks++;
    if (bus.rd_key !== R128_1) begin $display("FAIL b2b_r1: got %h expected %h", bus.rd_key, R128_1); fails++; end
    bus.rd_round = 4'd10;
    step();
    checks++;
    if ({bus.rd_valid, bus.rd_key} !== {1'b1, R128_10}) begin
      $display("FAIL b2b_r10: got rv=%b key=%h expected rv=1 key=%h", bus.rd_valid, bus.rd_key, R128_10);
      fails++;
    end
    bus.rd_en = 1'b0;
    step();
    checks++;
    if (bus.rd_valid !== 1'b0) begin $display("FAIL b2b_idle_valid: got %b expected 0", bus.rd_valid); fails++; end
  endtask
  task automatic test_illegal();
    bus.key_len = 2'd3;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if ({bus.err, bus.busy, bus.keys_valid} !== 3'b101) begin
      $display("FAIL bad_key_len: got err=%b busy=%b kv=%b expected err=1 busy=0 kv=1", bus.err, bus.busy, bus.keys_valid);
      fails++;
    end
    step();
    checks++;
    if ({bus.err, bus.busy} !== 2'b00) begin
      $display("FAIL bad_key_len_after: got err=%b busy=%b expected 0 0", bus.err, bus.busy);
      fails++;
    end
    rd(4'd11);
    checks++;
    if ({bus.rd_valid, bus.err, bus.rd_key} !== {2'b11, 128'h0}) begin
      $display("FAIL round_gt_nr: got rv=%b err=%b key=%h expected rv=1 err=1 key=0", bus.rd_valid, bus.err, bus.rd_key);
      fails++;
    end
  endtask
  task automatic test_aes256();
    int lat;
    logic e;
    expand(2'd2, K256, -1, lat, e);
    checks++;
    if ({lat, bus.nr} !== {32'd53, 4'd14}) begin
      $display("FAIL lat256: got lat=%0d nr=%0d expected lat=53 nr=14", lat, bus.nr);
      fails++;
    end
    rd(4'd14);
    checks++;
    if (bus.rd_key !== R256_14) begin $display("FAIL r256_14: got %h expected %h", bus.rd_key, R256_14); fails++; end
  endtask
  task automatic test_abort_restart();
    int lat;
    logic e;
    bus.key_len = 2'd2;
    bus.key_in = K256;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    rd(4'd3);
    checks++;
    if ({bus.rd_valid, bus.err, bus.rd_key, bus.busy} !== {2'b11, 128'h0, 1'b1}) begin
      $display("FAIL read_mid_expand: got rv=%b err=%b key=%h busy=%b expected rv=1 err=1 key=0 busy=1",
               bus.rd_valid, bus.err, bus.rd_key, bus.busy);
      fails++;
    end
    repeat (14) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.keys_valid, bus.nr, bus.rd_valid, bus.err, bus.rd_key} !== '0) begin
      $display("FAIL abort_outputs: got busy=%b done=%b kv=%b nr=%0d rv=%b err=%b key=%h expected all zero",
               bus.busy, bus.done, bus.keys_valid, bus.nr, bus.rd_valid, bus.err, bus.rd_key);
      fails++;
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({bus.busy, bus.keys_valid} !== 2'b00) begin
      $display("FAIL after_abort: got busy=%b kv=%b expected 0 0", bus.busy, bus.keys_valid);
      fails++;
    end
    expand(2'd0, {K128, JUNK}, 10, lat, e);
    checks++;
    if ({lat, bus.nr, e} !== {32'd41, 4'd10, 1'b0}) begin
      $display("FAIL restart_poke: got lat=%0d nr=%0d err_seen=%b expected lat=41 nr=10 err_seen=0", lat, bus.nr, e);
      fails++;
    end
    rd(4'd10);
    checks++;
    if (bus.rd_key !== R128_10) begin $display("FAIL restart_r10: got %h expected %h", bus.rd_key, R128_10); fails++; end
  endtask
`ifdef AES_KS_INV_KEY_EN
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction
  task automatic test_inv();
    bus.rd_en = 1'b1;
    bus.rd_inv = 1'b1;
    bus.rd_round = 4'd0;
    step();
    checks++;
    if (bus.rd_key !== K128) begin $display("FAIL inv_r0: got %h expected %h", bus.rd_key, K128); fails++; end
    bus.rd_round = 4'd10;
    step();
    checks++;
    if (bus.rd_key !== R128_10) begin $display("FAIL inv_r10: got %h expected %h", bus.rd_key, R128_10); fails++; end
    bus.rd_round = 4'd1;
    step();
    checks++;
    if (bus.rd_key === R128_1 || mix(bus.rd_key) !== R128_1) begin
      $display("FAIL inv_r1: got %h (mix %h) expected mix %h", bus.rd_key, mix(bus.rd_key), R128_1);
      fails++;
    end
    bus.rd_en = 1'b0;
    bus.rd_inv = 1'b0;
  endtask
`endif
  task automatic test_read_with_start();
    int lat;
    bus.key_len = 2'd1;
    bus.key_in = {K192, JUNK[63:0]};
    bus.start = 1'b1;
    bus.rd_en = 1'b1;
    bus.rd_round = 4'd10;
    step();
    bus.start = 1'b0;
    bus.rd_en = 1'b0;
    checks++;
    if ({bus.rd_key, bus.err, bus.keys_valid, bus.busy} !== {R128_10, 3'b001}) begin
      $display("FAIL read_with_start: got key=%h err=%b kv=%b busy=%b expected key=%h err=0 kv=0 busy=1",
               bus.rd_key, bus.err, bus.keys_valid, bus.busy, R128_10);
      fails++;
    end
    lat = 0;
    while (!bus.done && lat < 100) begin step(); lat++; end
    checks++;
    if ({lat, bus.nr} !== {32'd47, 4'd12}) begin
      $display("FAIL lat192: got lat=%0d nr=%0d expected lat=47 nr=12", lat, bus.nr);
      fails++;
    end
    rd(4'd12);
    checks++;
    if (bus.rd_key !== R192_12) begin $display("FAIL r192_12: got %h expected %h", bus.rd_key, R192_12); fails++; end
    rd(4'd0);
    checks++;
    if (bus.rd_key !== K192[191:64]) begin $display("FAIL r192_0: got %h expected %h", bus.rd_key, K192[191:64]); fails++; end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.key_len = 2'd0;
    bus.key_in = '0;
    bus.rd_en = 1'b0;
    bus.rd_round = 4'd0;
`ifdef AES_KS_INV_KEY_EN
    bus.rd_inv = 1'b0;
`endif
    test_reset();
    test_aes128();
    test_back_to_back();
    test_illegal();
    test_aes256();
    test_abort_restart();
`ifdef AES_KS_INV_KEY_EN
    test_inv();
`endif
    test_read_with_start();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
